fifo_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one simple_fifo write port among NREQ producers.

---
 rtl/fifo_rr_arbiter_pkg.sv | 4 +
 rtl/fifo_rr_arbiter_defs.vh | 19 +
 rtl/fifo_rr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Package for the round-robin FIFO write-port arbiter; wraps the shared defs include.
package fifo_rr_arbiter_pkg;
`include "fifo_rr_arbiter_defs.vh"
endpackage

// File: rtl/fifo_rr_arbiter_defs.vh
// Shared definitions for the fifo_rr_arbiter slice: state encodings and clog2.
`ifndef FIFO_RR_ARBITER_DEFS_VH
`define FIFO_RR_ARBITER_DEFS_VH

typedef enum logic {
   ST_IDLE  = 1'b0,
   ST_GRANT = 1'b1
} state_e;

function automatic int clog2(input int n);
   int res;
   res = 0;
   for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) res = i + 1;
   end
   return res;
endfunction

`endif

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after start,
// optionally skipping one excluded index.
module rr_pick
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] start,
   input  logic            exclude_en,
   input  logic [ID_W-1:0] exclude_id,
   output logic            found,
   output logic [ID_W-1:0] winner
);

   always_comb begin
      int idx;
      logic [ID_W-1:0] idx_id;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_id = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(start) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_id = ID_W'(idx);
         if (!found && req[idx_id] && !(exclude_en && (idx_id == exclude_id))) begin
            found  = 1'b1;
            winner = idx_id;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers in bursts.
// Optional counters stall_cycles/grant_count enabled by FIFO_RR_ARBITER_STATS_EN.
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int  WIDTH     = 32,
   parameter int  NREQ      = 4,
   parameter int  BURST_LEN = 4,
   localparam int ID_W      = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  fifo_we,
   output logic [WIDTH-1:0]      fifo_din,
   input  logic                  fifo_full,
   output logic [ID_W-1:0]       grant_id,
   output logic                  busy
`ifdef FIFO_RR_ARBITER_STATS_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           grant_count
`endif
);

   localparam int CNT_W = clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LEN - 1);

   state_e          state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [ID_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic            in_grant, g_valid, beat, release_now, load;
   logic            pick_found;
   logic [ID_W-1:0] pick_winner, pick_start;

   assign in_grant = (state_q == ST_GRANT);
   assign g_valid  = req_valid[grant_id_q];
   assign beat     = in_grant && g_valid && !fifo_full;
   assign busy     = in_grant;
   assign grant_id = grant_id_q;

   // The pointer always names the last winner, so one picker start serves IDLE and release.
   assign pick_start = (last_q == ID_W'(NREQ - 1)) ? '0 : last_q + ID_W'(1);

   rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
      .req        (req_valid),
      .start      (pick_start),
      .exclude_en (in_grant && !g_valid),
      .exclude_id (grant_id_q),
      .found      (pick_found),
      .winner     (pick_winner)
   );

   assign release_now = in_grant && (!g_valid || (beat && (beat_cnt_q == BEAT_LAST)));

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = '0;
      fifo_we    = 1'b0;
      fifo_din   = req_data[grant_id_q*WIDTH +: WIDTH];
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) load = 1'b1;
         end
         ST_GRANT: begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_we               = beat;
            if (beat) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (release_now) begin
               if (pick_found) begin
                  load = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
                  beat_cnt_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         state_d    = ST_GRANT;
         grant_id_d = pick_winner;
         last_d     = pick_winner;
         beat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         last_q     <= ID_W'(NREQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_RR_ARBITER_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] grant_count_q, grant_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      grant_count_d  = grant_count_q;
      if (in_grant && g_valid && fifo_full) stall_cycles_d = sat_inc(stall_cycles_q);
      if (load) grant_count_d = sat_inc(grant_count_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         grant_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         grant_count_q  <= grant_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign grant_count  = grant_count_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_fifo_rr_arbiter;
   localparam int WIDTH = 32, NREQ = 4, BURST_LEN = 4, ID_W = 2, DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_we;
   logic [WIDTH-1:0]      fifo_din;
   logic                  fifo_full = 1'b0;
   logic [ID_W-1:0]       grant_id;
   logic                  busy;
`ifdef FIFO_RR_ARBITER_STATS_EN
   logic [31:0]           stall_cycles, grant_count;
`endif

   fifo_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_LEN(BURST_LEN)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_we(fifo_we), .fifo_din(fifo_din),
      .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_RR_ARBITER_STATS_EN
      , .stall_cycles(stall_cycles), .grant_count(grant_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          rem [NREQ];
   int          seq [NREQ];
   logic [31:0] base [NREQ];
   int          fifo_cnt = 0;
   bit          fifo_re = 0, rnd_mode = 0;
   int          cyc = 0;
   int          log_id [$];
   logic [31:0] log_data [$];
   int          log_cyc [$];
   int          m_busy, m_gid, m_last, m_cnt, m_stall, m_grants;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int start, input int excl);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (start + k) % NREQ;
         if (v[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_gid = 0; m_last = NREQ - 1; m_cnt = 0; m_stall = 0; m_grants = 0;
   endtask

   task automatic grant_to(input int w);
      m_busy = 1; m_gid = w; m_last = w; m_cnt = 0; m_grants++;
   endtask

   // One step of the reference behaviour, from pre-edge inputs.
   task automatic model_step();
      int w;
      bit vg;
      if (m_busy == 0) begin
         w = pick(req_valid, (m_last + 1) % NREQ, -1);
         if (w >= 0) grant_to(w);
      end else begin
         vg = req_valid[m_gid];
         if (vg && fifo_full) m_stall++;
         if (vg && !fifo_full) m_cnt++;
         if (!vg || m_cnt == BURST_LEN) begin
            w = pick(req_valid, (m_gid + 1) % NREQ, vg ? -1 : m_gid);
            if (w >= 0) grant_to(w);
            else m_busy = 0;
         end
      end
   endtask

   // Edge process: model, environment FIFO occupancy, producer sequence, beat log.
   initial begin
      logic [NREQ-1:0]  rdy;
      logic             we;
      logic [WIDTH-1:0] din;
      logic [ID_W-1:0]  gid;
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            model_reset();
         end else begin
            rdy = req_ready; we = fifo_we; din = fifo_din; gid = grant_id;
            model_step();
            for (int i = 0; i < NREQ; i++) begin
               if (req_valid[i] && rdy[i]) begin
                  seq[i]++;
                  if (rem[i] > 0) rem[i]--;
               end
            end
            if (we) begin
               log_id.push_back(int'(gid)); log_data.push_back(din); log_cyc.push_back(cyc);
            end
            fifo_cnt = fifo_cnt + (we ? 1 : 0) - ((fifo_re && fifo_cnt > 0) ? 1 : 0);
            cyc++;
         end
      end
   end

   // Input driver, away from the active edge.
   initial begin
      forever begin
         @(negedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (rnd_mode) req_valid[i] = ($urandom_range(0, 3) != 0);
            else req_valid[i] = (rem[i] > 0);
            req_data[i*WIDTH +: WIDTH] = base[i] + 32'(seq[i]);
         end
         if (rnd_mode) fifo_re = ($urandom_range(0, 1) == 1);
         fifo_full = (fifo_cnt >= DEPTH);
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      logic [NREQ-1:0] exp_ready;
      forever begin
         @(negedge clk); #3;
         exp_ready = '0;
         if (m_busy != 0 && !fifo_full) exp_ready[m_gid] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         chk("fifo_we", 64'(fifo_we), 64'(m_busy != 0 && req_valid[m_gid] && !fifo_full));
         chk("busy", 64'(busy), 64'(m_busy != 0));
         chk("grant_id", 64'(grant_id), 64'(m_gid));
         if (m_busy != 0) chk("fifo_din", 64'(fifo_din), 64'(req_data[m_gid*WIDTH +: WIDTH]));
`ifdef FIFO_RR_ARBITER_STATS_EN
         chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
         chk("grant_count", 64'(grant_count), 64'(m_grants));
`endif
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; rnd_mode = 0; fifo_re = 0; fifo_cnt = 0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0; seq[i] = 0; base[i] = 32'(i) << 24;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      log_id.delete(); log_data.delete(); log_cyc.delete();
   endtask

   task automatic wait_beats(input int n);
      int t;
      t = 0;
      while (log_id.size() < n && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("beat_wait", 64'(log_id.size() >= n), 64'd1);
   endtask

   initial begin
      int c0;
      int exp4 [8] = '{2, 2, 3, 3, 3, 3, 3, 3};
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 1; seq[i] = 0; base[i] = '0;
      end
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_fifo_we", 64'(fifo_we), 64'd0);

      // Single requester, 6 beats: bursts of 4 then direct re-grant.
      do_reset();
      base[0] = 32'h100; rem[0] = 6; c0 = cyc;
      wait_beats(6);
      repeat (4) @(negedge clk);
      chk("s1_count", 64'(log_id.size()), 64'd6);
      for (int k = 0; k < 6 && k < log_id.size(); k++) begin
         chk("s1_data", 64'(log_data[k]), 64'(32'h100 + k));
         chk("s1_id", 64'(log_id[k]), 64'd0);
      end
      if (log_id.size() >= 6) begin
         chk("s1_latency", 64'(log_cyc[0] - c0), 64'd1);
         chk("s1_span", 64'(log_cyc[5] - log_cyc[0]), 64'd5);
      end
      chk("s1_fifo_cnt", 64'(fifo_cnt), 64'd6);
      chk("s1_idle", 64'(busy), 64'd0);

      // All four valid: rotation 0,1,2,3,0,... with no bubbles.
      do_reset();
      fifo_re = 1;
      for (int i = 0; i < NREQ; i++) rem[i] = 8;
      wait_beats(32);
      for (int k = 0; k < 32 && k < log_id.size(); k++)
         chk("s2_id", 64'(log_id[k]), 64'((k / 4) % 4));
      if (log_id.size() >= 32) chk("s2_span", 64'(log_cyc[31] - log_cyc[0]), 64'd31);

      // Full FIFO: requester 1 stalls, then two single pops let exactly two beats in.
      do_reset();
      fifo_cnt = DEPTH; rem[1] = 100;
      repeat (6) @(negedge clk);
      #2;
      chk("s3_we_full", 64'(fifo_we), 64'd0);
      chk("s3_ready_full", 64'(req_ready), 64'd0);
      chk("s3_busy", 64'(busy), 64'd1);
      chk("s3_none", 64'(log_id.size()), 64'd0);
      for (int p = 0; p < 2; p++) begin
         @(negedge clk); fifo_re = 1;
         @(negedge clk); fifo_re = 0;
         repeat (4) @(negedge clk);
      end
      chk("s3_beats", 64'(log_id.size()), 64'd2);
      chk("s3_grant_id", 64'(grant_id), 64'd1);
      chk("s3_fifo_cnt", 64'(fifo_cnt), 64'(DEPTH));
`ifdef FIFO_RR_ARBITER_STATS_EN
      chk("s3_grant_count", 64'(grant_count), 64'd1);
      chk("s3_stall_nonzero", 64'(stall_cycles > 32'd5), 64'd1);
`endif

      // Requester 2 drops valid after two beats; requester 3 takes over next cycle.
      do_reset();
      fifo_re = 1; rem[2] = 2; rem[3] = 6;
      wait_beats(8);
      for (int k = 0; k < 8 && k < log_id.size(); k++)
         chk("s4_id", 64'(log_id[k]), 64'(exp4[k]));
      if (log_id.size() >= 8) begin
         chk("s4_release_gap", 64'(log_cyc[2] - log_cyc[1]), 64'd2);
         chk("s4_r3_span", 64'(log_cyc[7] - log_cyc[2]), 64'd5);
      end

      // Reset mid-burst aborts at once; pointer restarts at requester 0.
      do_reset();
      fifo_re = 1; rem[1] = 10;
      wait_beats(2);
      reset = 1'b1;
      #1;
      chk("s5_busy", 64'(busy), 64'd0);
      chk("s5_grant_id", 64'(grant_id), 64'd0);
      chk("s5_req_ready", 64'(req_ready), 64'd0);
      chk("s5_fifo_we", 64'(fifo_we), 64'd0);
      rem[0] = 10; rem[1] = 10;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      log_id.delete(); log_data.delete(); log_cyc.delete();
      wait_beats(1);
      if (log_id.size() >= 1) chk("s5_first_winner", 64'(log_id[0]), 64'd0);

      // Random traffic and backpressure.
      do_reset();
      rnd_mode = 1;
      repeat (3000) @(negedge clk);
      rnd_mode = 0;
      chk("rand_progress", 64'(log_id.size() > 500), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
